// File: rtl/subtrator_pkg.sv
// Shared state encoding for the bit-serial subtractor.
package subtrator_pkg;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_SHIFT = ST_SHIFT,
        S_DONE  = ST_DONE
    } state_t;
endpackage

// File: rtl/subtrator_completo_1bit.sv
// Combinational 1-bit full subtractor: d = x - y - bin.
module subtrator_completo_1bit (
    input  logic x,
    input  logic y,
    input  logic bin,
    output logic d,
    output logic bout
);
    assign d    = x ^ y ^ bin;
    assign bout = (~x & y) | (~(x ^ y) & bin);
endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor, LSB first, with start/done handshake.
// state  | meaning
// IDLE   | waiting for start; operands captured when start=1
// SHIFT  | one difference bit per cycle through the 1-bit subtractor
// DONE   | publish d/bout/ovf, pulse done, return to IDLE
module subtrator_serial
    import subtrator_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bout,
    output logic         ovf
);
    localparam int CW = $clog2(N + 1);

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [N-1:0]   a_sr;
    logic [N-1:0]   b_sr;
    logic [N-1:0]   d_sr;
    logic           borrow_q;
    logic           a_msb;
    logic           b_msb;
    logic           diff_bit;
    logic           bo_bit;

    subtrator_completo_1bit u_fs (
        .x   (a_sr[0]),
        .y   (b_sr[0]),
        .bin (borrow_q),
        .d   (diff_bit),
        .bout(bo_bit)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            a_sr     <= '0;
            b_sr     <= '0;
            d_sr     <= '0;
            borrow_q <= 1'b0;
            a_msb    <= 1'b0;
            b_msb    <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            d        <= '0;
            bout     <= 1'b0;
            ovf      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (start) begin
                        a_sr     <= a;
                        b_sr     <= b;
                        borrow_q <= bin;
                        a_msb    <= a[N-1];
                        b_msb    <= b[N-1];
                        cnt      <= '0;
                        busy     <= 1'b1;
                        state    <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    // Difference bits enter at the MSB so bit 0 ends up at d[0].
                    d_sr     <= {diff_bit, d_sr[N-1:1]};
                    a_sr     <= a_sr >> 1;
                    b_sr     <= b_sr >> 1;
                    borrow_q <= bo_bit;
                    cnt      <= cnt + 1'b1;
                    if (cnt == CW'(N - 1))
                        state <= S_DONE;
                end
                S_DONE: begin
                    d     <= d_sr;
                    bout  <= borrow_q;
                    ovf   <= (a_msb != b_msb) && (d_sr[N-1] != a_msb);
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= S_IDLE;
                end
            endcase
        end
    end
endmodule
